inst_fetch_ctrl: RTL and testbench

- Sequences the instruction memory for the pipelined core.
- Generates word-aligned fetch addresses and runs a req/ack handshake so combinational ROM and multi-cycle SRAM-backed instruction stores can both be used.
- Buffers returned instructions in a small prefetch queue toward the IF/ID register.
- Applies branch/jump redirects from EXE, including flushing the queue and discarding any in-flight fetch.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/inst_fetch_ctrl_fetch_queue.sv | 93 +++++++++
 rtl/inst_fetch_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Types and constants shared by the instruction fetch path.
//   fetch_state_t   : fetch controller state encoding
//   fetch_entry_t   : prefetch queue entry {inst, pc}
//   WORD_BYTES      : bytes per instruction word
//   NOP_INST        : all-zero instruction word
//   RESET_PC_DEFAULT: default first fetch address
//   word_align()    : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package cpu_pkg;

   typedef enum logic [1:0] {
      S_REQ     = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_entry_t;

   localparam int unsigned WORD_BYTES       = 4;
   localparam logic [31:0] NOP_INST         = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   function automatic logic [31:0] word_align(input logic [31:0] adrs);
      return {adrs[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch_ctrl_fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Synchronous FIFO of {inst, pc} entries with a registered head.
// Flush has priority over push and pop. Push is accepted when not full or
// when a pop happens in the same cycle. When the queue runs empty the head
// register keeps its last contents.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, wdata       : write request and entry
//   pop               : remove head (ignored when empty)
//   flush             : clear the queue
//   head              : registered oldest entry
//   count, full, empty: occupancy status
// ---------------------------------------------------------------------------
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_entry_t  wdata,
   output fetch_entry_t  head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   fetch_entry_t  mem_r [DEPTH];
   fetch_entry_t  head_r;
   fetch_entry_t  head_nxt_s;
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] rd_nxt_s;
   logic [CW-1:0] count_r;
   logic [CW-1:0] cnt_after_pop_s;
   logic [CW-1:0] cnt_nxt_s;
   logic          pop_s;
   logic          push_s;

   // Qualified push/pop, next occupancy and next head entry.
   always_comb begin
      pop_s           = pop & (count_r != {CW{1'b0}});
      push_s          = push & ((count_r != CW'(DEPTH)) | pop_s);
      rd_nxt_s        = rd_ptr_r + AW'(pop_s);
      cnt_after_pop_s = count_r - CW'(pop_s);
      cnt_nxt_s       = cnt_after_pop_s + CW'(push_s);
      // With nothing left after the pop, the new head is the incoming entry.
      if (cnt_after_pop_s == {CW{1'b0}}) begin
         head_nxt_s = wdata;
      end else begin
         head_nxt_s = mem_r[rd_nxt_s];
      end
   end

   // Storage, pointers, occupancy and registered head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         head_r   <= '{inst: NOP_INST, pc: 32'h0000_0000};
      end else if (flush) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         rd_ptr_r <= rd_nxt_s;
         count_r  <= cnt_nxt_s;
         if (cnt_nxt_s != {CW{1'b0}}) begin
            head_r <= head_nxt_s;
         end
      end
   end

   assign head  = head_r;
   assign count = count_r;
   assign full  = (count_r == CW'(DEPTH));
   assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/inst_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// inst_fetch_ctrl
// Instruction fetch sequencer: issues word-aligned fetch requests with a
// req/ack handshake, buffers returned words in a prefetch queue toward IF/ID
// and applies EXE redirects (queue flush, in-flight fetch discard).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   imem_req, imem_adrs   : fetch request and byte address (held until ack)
//   imem_ack, imem_inst   : memory response
//   br_taken, br_target   : redirect from EXE
//   if_valid, if_ready    : head handshake toward IF/ID
//   if_inst, if_pc        : registered head instruction and its address
// Optional (macro IFETCH_PERF_EN): perf_fetched, perf_discarded, perf_stall
//   32-bit saturating event counters.
// ---------------------------------------------------------------------------
module inst_fetch_ctrl
   import cpu_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_adrs,
   input  logic        imem_ack,
   input  logic [31:0] imem_inst,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_discarded,
   output logic [31:0] perf_stall
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t  state_r, state_nxt_s;
   logic [31:0]   fetch_pc_r, fetch_pc_nxt_s;
   logic [31:0]   hold_adrs_r, hold_adrs_nxt_s;
   logic          req_s;
   logic          ack_s;
   logic          push_s;
   logic          pop_s;
   logic          pop_raw_s;
   fetch_entry_t  q_head_s;
   logic [CW-1:0] q_count_s;
   logic          q_full_s;
   logic          q_empty_s;

   assign pop_raw_s = if_valid & if_ready;
   assign ack_s     = req_s & imem_ack;
   // Data returned while discarding or during a redirect is never queued.
   assign push_s    = ack_s & ~br_taken & (state_r != S_DISCARD);
   assign pop_s     = pop_raw_s & ~br_taken;

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (pop_s),
      .flush (br_taken),
      .wdata ('{inst: imem_inst, pc: fetch_pc_r}),
      .head  (q_head_s),
      .count (q_count_s),
      .full  (q_full_s),
      .empty (q_empty_s)
   );

   assign if_valid = ~q_empty_s;
   assign if_inst  = q_head_s.inst;
   assign if_pc    = q_head_s.pc;

   // State, fetch PC and held discard address registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_REQ;
         fetch_pc_r  <= RESET_PC;
         hold_adrs_r <= RESET_PC;
      end else begin
         state_r     <= state_nxt_s;
         fetch_pc_r  <= fetch_pc_nxt_s;
         hold_adrs_r <= hold_adrs_nxt_s;
      end
   end

   // Next-state, fetch PC and held address; redirect has highest priority.
   always_comb begin
      state_nxt_s     = state_r;
      fetch_pc_nxt_s  = fetch_pc_r;
      hold_adrs_nxt_s = hold_adrs_r;
      if (br_taken) begin
         fetch_pc_nxt_s = word_align(br_target);
         case (state_r)
            S_WAIT: begin
               if (!imem_ack) begin
                  state_nxt_s     = S_DISCARD;
                  hold_adrs_nxt_s = fetch_pc_r;
               end else begin
                  state_nxt_s = S_REQ;
               end
            end
            S_DISCARD: begin
               if (!imem_ack) begin
                  state_nxt_s = S_DISCARD;
               end else begin
                  state_nxt_s = S_REQ;
               end
            end
            default: state_nxt_s = S_REQ;
         endcase
      end else begin
         case (state_r)
            S_REQ: begin
               if (req_s && !imem_ack) begin
                  state_nxt_s = S_WAIT;
               end else begin
                  state_nxt_s = S_REQ;
               end
            end
            S_WAIT: begin
               if (imem_ack) begin
                  state_nxt_s = S_REQ;
               end else begin
                  state_nxt_s = S_WAIT;
               end
            end
            S_DISCARD: begin
               if (imem_ack) begin
                  state_nxt_s = S_REQ;
               end else begin
                  state_nxt_s = S_DISCARD;
               end
            end
            default: state_nxt_s = S_REQ;
         endcase
         if (push_s) begin
            fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
         end else begin
            fetch_pc_nxt_s = fetch_pc_r;
         end
      end
   end

   // Memory-side outputs: request qualification and address selection.
   always_comb begin
      case (state_r)
         S_REQ:     req_s = (q_count_s < CW'(DEPTH)) | pop_raw_s;
         S_WAIT:    req_s = 1'b1;
         S_DISCARD: req_s = 1'b1;
         default:   req_s = 1'b0;
      endcase
      // The discarded request keeps its own address until it is acked.
      if (state_r == S_DISCARD) begin
         imem_adrs = hold_adrs_r;
      end else begin
         imem_adrs = fetch_pc_r;
      end
   end

   assign imem_req = rst_n & req_s;

`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetched_r;
   logic [31:0] perf_discarded_r;
   logic [31:0] perf_stall_r;

   // Saturating event counters for pushed acks, dropped acks and stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched_r   <= 32'd0;
         perf_discarded_r <= 32'd0;
         perf_stall_r     <= 32'd0;
      end else begin
         if (push_s && (perf_fetched_r != 32'hFFFF_FFFF)) begin
            perf_fetched_r <= perf_fetched_r + 32'd1;
         end
         if (ack_s && !push_s && (perf_discarded_r != 32'hFFFF_FFFF)) begin
            perf_discarded_r <= perf_discarded_r + 32'd1;
         end
         if (if_valid && !if_ready && (perf_stall_r != 32'hFFFF_FFFF)) begin
            perf_stall_r <= perf_stall_r + 32'd1;
         end
      end
   end

   assign perf_fetched   = perf_fetched_r;
   assign perf_discarded = perf_discarded_r;
   assign perf_stall     = perf_stall_r;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_ctrl
// Drives inst_fetch_ctrl with directed and random stimulus against a
// behavioural model (a queue of {inst, pc} plus outstanding/dropping flags).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

   localparam int DEPTH = 2;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_adrs;
   logic        imem_ack;
   logic [31:0] imem_inst;
   logic        br_taken;
   logic [31:0] br_target;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_discarded;
   logic [31:0] perf_stall;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   // model state
   ent_t        mq[$];
   logic [31:0] m_pc;
   logic [31:0] m_hold;
   logic [31:0] m_inst;
   logic [31:0] m_hpc;
   bit          m_wait;
   bit          m_drop;
   int          m_fetch;
   int          m_disc;
   int          m_stall;

   // memory stub state
   bit          mem_busy;
   logic [31:0] mem_adrs;
   int          mem_left;

   inst_fetch_ctrl #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .imem_req  (imem_req),
      .imem_adrs (imem_adrs),
      .imem_ack  (imem_ack),
      .imem_inst (imem_inst),
      .br_taken  (br_taken),
      .br_target (br_target),
      .if_valid  (if_valid),
      .if_ready  (if_ready),
      .if_inst   (if_inst),
      .if_pc     (if_pc)
`ifdef IFETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_discarded (perf_discarded),
      .perf_stall     (perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      if (a == 32'd4) return 32'h8001_060A;
      return {~a[15:0], a[15:0]} ^ 32'h0000_0013;
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc = 32'd0; m_hold = 32'd0; m_inst = 32'd0; m_hpc = 32'd0;
      m_wait = 1'b0; m_drop = 1'b0;
      m_fetch = 0; m_disc = 0; m_stall = 0;
      mem_busy = 1'b0; mem_left = 0; mem_adrs = 32'd0;
   endtask

   // One clock cycle: called at a falling edge, returns at the next one.
   task automatic cycle(input bit br, input logic [31:0] tgt, input bit rdy, input int lat);
      bit          exp_req, exp_valid, ack, fire, pushed;
      logic [31:0] exp_adrs;
      br_taken  = br;
      br_target = tgt;
      if_ready  = rdy;
      imem_ack  = 1'b0;
      #1;
      exp_valid = (mq.size() > 0);
      exp_req   = m_wait || m_drop || (mq.size() < DEPTH) || (exp_valid && rdy);
      exp_adrs  = m_drop ? m_hold : m_pc;
      check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      check("imem_adrs", imem_adrs, exp_adrs);
      check("if_valid", {31'd0, if_valid}, {31'd0, exp_valid});
      check("if_inst", if_inst, m_inst);
      check("if_pc", if_pc, m_hpc);
`ifdef IFETCH_PERF_EN
      check("perf_fetched", perf_fetched, m_fetch);
      check("perf_discarded", perf_discarded, m_disc);
      check("perf_stall", perf_stall, m_stall);
`endif
      // memory stub: latency counted from the first cycle an address is seen
      ack = 1'b0;
      if (imem_req) begin
         if (!mem_busy || imem_adrs != mem_adrs) begin
            mem_busy = 1'b1; mem_adrs = imem_adrs; mem_left = lat;
         end
         if (mem_left == 0) begin ack = 1'b1; mem_busy = 1'b0; end
         else mem_left--;
      end else begin
         mem_busy = 1'b0;
      end
      imem_ack  = ack;
      imem_inst = ack ? rom(imem_adrs) : $urandom;
      // model update for the coming rising edge
      fire   = exp_req && ack;
      pushed = fire && !br && !m_drop;
      if (pushed) m_fetch++;
      if (fire && !pushed) m_disc++;
      if (exp_valid && !rdy) m_stall++;
      if (br) begin
         if ((m_wait || m_drop) && !ack) begin
            if (m_wait) m_hold = m_pc;
            m_drop = 1'b1;
         end else begin
            m_drop = 1'b0;
         end
         m_wait = 1'b0;
         mq.delete();
         m_pc = tgt & 32'hFFFF_FFFC;
      end else begin
         if (exp_valid && rdy) void'(mq.pop_front());
         if (pushed) begin
            mq.push_back('{inst: rom(m_pc), pc: m_pc});
            m_pc   = m_pc + 32'd4;
            m_wait = 1'b0;
         end else if (fire) begin
            m_drop = 1'b0;
         end else if (exp_req && !m_drop) begin
            m_wait = 1'b1;
         end
      end
      if (mq.size() > 0) begin
         m_inst = mq[0].inst;
         m_hpc  = mq[0].pc;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] old_adrs;
      int          disc0;
      rst_n = 1'b0; imem_ack = 1'b0; imem_inst = 32'd0;
      br_taken = 1'b0; br_target = 32'd0; if_ready = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_adrs", imem_adrs, 32'd0);
      check("rst_valid", {31'd0, if_valid}, 32'd0);
      check("rst_inst", if_inst, 32'd0);
      check("rst_pc", if_pc, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: combinational ROM streaming
      cycle(1'b0, 32'd0, 1'b1, 0);
      check("t1_valid_c2", {31'd0, if_valid}, 32'd1);
      check("t1_pc0", if_pc, 32'd0);
      cycle(1'b0, 32'd0, 1'b1, 0);
      check("t1_pc4", if_pc, 32'd4);
      check("t1_inst4", if_inst, 32'h8001_060A);
      repeat (6) cycle(1'b0, 32'd0, 1'b1, 0);

      // 2: freeze for 5 cycles, then resume
      repeat (5) cycle(1'b0, 32'd0, 1'b0, 0);
      #1;
      check("t2_req_full", {31'd0, imem_req}, 32'd0);
      repeat (4) cycle(1'b0, 32'd0, 1'b1, 0);

      // 3: redirect in S_REQ with a full queue
      repeat (2) cycle(1'b0, 32'd0, 1'b0, 0);
      cycle(1'b1, 32'h0000_00B4, 1'b0, 0);
      check("t3_valid", {31'd0, if_valid}, 32'd0);
      check("t3_adrs", imem_adrs, 32'h0000_00B4);
      cycle(1'b0, 32'd0, 1'b1, 0);
      check("t3_head_pc", if_pc, 32'h0000_00B4);
      repeat (2) cycle(1'b0, 32'd0, 1'b1, 0);

      // 4: redirect while waiting on slow memory
      old_adrs = imem_adrs;
      cycle(1'b0, 32'd0, 1'b1, 2);
      cycle(1'b1, 32'h0000_0100, 1'b1, 2);
      check("t4_adrs_held", imem_adrs, old_adrs);
      cycle(1'b0, 32'd0, 1'b1, 2);
      check("t4_adrs_tgt", imem_adrs, 32'h0000_0100);
      repeat (4) cycle(1'b0, 32'd0, 1'b1, 0);

      // 5: ack, pop and redirect in one cycle
      disc0 = m_disc;
      cycle(1'b1, 32'h0000_0040, 1'b1, 0);
      check("t5_valid", {31'd0, if_valid}, 32'd0);
      check("t5_disc_model", m_disc, disc0 + 1);
      repeat (3) cycle(1'b0, 32'd0, 1'b1, 0);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         cycle(($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 3) != 0),
               $urandom_range(0, 3));
      end

      // 6: asynchronous reset while waiting
      cycle(1'b0, 32'd0, 1'b0, 3);
      cycle(1'b0, 32'd0, 1'b0, 3);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_req", {31'd0, imem_req}, 32'd0);
      check("t6_valid", {31'd0, if_valid}, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0, 32'd0, 1'b1, 0);
      check("t6_restart_pc", if_pc, 32'd0);
      repeat (5) cycle(1'b0, 32'd0, 1'b1, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
